// File: rtl/pong_game_logic.sv
// Frame-rate Pong engine: paddle motion, ball physics, scoring and the serve/win sequence.
// All positions advance once per frame_tick so they stay stable while a frame is scanned out.
module pong_game_logic #(
    parameter logic [10:0] BALL_SIZE    = 11'd20,
    parameter logic [10:0] PAD_HEIGHT   = 11'd100,
    parameter logic [10:0] PAD_WIDTH    = 11'd10,
    parameter logic [10:0] PAD_OFFS     = 11'd35,
    parameter logic [10:0] H_RES        = 11'd1280,
    parameter logic [10:0] V_RES        = 11'd800,
    parameter logic [10:0] BALL_SPEED   = 11'd4,
    parameter logic [10:0] PAD_SPEED    = 11'd6,
    parameter logic [7:0]  SERVE_FRAMES = 8'd60,
    parameter logic [3:0]  WIN_SCORE    = 4'd9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        btn_l_up,
    input  logic        btn_l_dn,
    input  logic        btn_r_up,
    input  logic        btn_r_dn,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [10:0] padl_y,
    output logic [10:0] padr_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        point_pulse,
    output logic        game_over
);

    localparam logic [10:0] BALL_X0    = (H_RES - BALL_SIZE) / 11'd2;
    localparam logic [10:0] BALL_Y0    = (V_RES - BALL_SIZE) / 11'd2;
    localparam logic [10:0] PAD_Y0     = (V_RES - PAD_HEIGHT) / 11'd2;
    localparam logic [10:0] PAD_Y_MAX  = V_RES - PAD_HEIGHT;
    localparam logic [10:0] BALL_Y_MAX = V_RES - BALL_SIZE;
    localparam logic [10:0] L_FACE     = PAD_OFFS + PAD_WIDTH;
    localparam logic [10:0] R_FACE     = H_RES - PAD_OFFS - PAD_WIDTH - 11'd1;
    localparam logic [10:0] R_BALL_X   = R_FACE - BALL_SIZE;

    localparam logic signed [11:0] S_BALL_SIZE  = {1'b0, BALL_SIZE};
    localparam logic signed [11:0] S_PAD_HEIGHT = {1'b0, PAD_HEIGHT};
    localparam logic signed [11:0] S_H_RES      = {1'b0, H_RES};
    localparam logic signed [11:0] S_BALL_SPEED = {1'b0, BALL_SPEED};
    localparam logic signed [11:0] S_PAD_SPEED  = {1'b0, PAD_SPEED};
    localparam logic signed [11:0] S_PAD_Y_MAX  = {1'b0, PAD_Y_MAX};
    localparam logic signed [11:0] S_BALL_Y_MAX = {1'b0, BALL_Y_MAX};
    localparam logic signed [11:0] S_L_FACE     = {1'b0, L_FACE};
    localparam logic signed [11:0] S_R_FACE     = {1'b0, R_FACE};

    typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_PLAY, ST_OVER} state_t;

    state_t            state_reg, state_next;
    logic [10:0]       ball_x_reg, ball_x_next;
    logic [10:0]       ball_y_reg, ball_y_next;
    logic              dx_pos_reg, dx_pos_next;
    logic              dy_pos_reg, dy_pos_next;
    logic [1:0][10:0]  pad_y_reg, pad_y_next, pad_moved;
    logic [3:0]        score_l_reg, score_l_next;
    logic [3:0]        score_r_reg, score_r_next;
    logic [7:0]        serve_cnt_reg, serve_cnt_next;
    logic              point_pulse_reg, point_pulse_next;
    logic              game_over_reg, game_over_next;

    // Index 0 is the left paddle, index 1 the right one.
    logic [1:0] btn_up, btn_dn;
    assign btn_up = {btn_r_up, btn_l_up};
    assign btn_dn = {btn_r_dn, btn_l_dn};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pad
            logic signed [11:0] y_s, y_up, y_dn;
            logic [10:0]        moved;
            assign y_s  = {1'b0, pad_y_reg[gi]};
            assign y_up = y_s - S_PAD_SPEED;
            assign y_dn = y_s + S_PAD_SPEED;
            always_comb begin
                moved = pad_y_reg[gi];
                if (btn_up[gi] && !btn_dn[gi]) begin
                    moved = (y_up < 12'sd0) ? 11'd0 : y_up[10:0];
                end else if (btn_dn[gi] && !btn_up[gi]) begin
                    moved = (y_dn > S_PAD_Y_MAX) ? PAD_Y_MAX : y_dn[10:0];
                end
            end
            assign pad_moved[gi] = moved;
        end
    endgenerate

    // Ball geometry, all on pre-move positions.
    logic signed [11:0] bx_s, by_s, pl_s, pr_s, by_up, by_dn;
    logic               overlap_l, overlap_r, hit_l, hit_r, miss_left_wall, miss_right_wall;
    logic [10:0]        y_new;
    logic               dy_new;
    logic [3:0]         score_l_inc, score_r_inc;
    logic [7:0]         serve_cnt_inc;

    assign bx_s  = {1'b0, ball_x_reg};
    assign by_s  = {1'b0, ball_y_reg};
    assign pl_s  = {1'b0, pad_y_reg[0]};
    assign pr_s  = {1'b0, pad_y_reg[1]};
    assign by_up = by_s - S_BALL_SPEED;
    assign by_dn = by_s + S_BALL_SPEED;

    assign overlap_l = (by_s + S_BALL_SIZE > pl_s) && (by_s < pl_s + S_PAD_HEIGHT);
    assign overlap_r = (by_s + S_BALL_SIZE > pr_s) && (by_s < pr_s + S_PAD_HEIGHT);
    assign hit_l = !dx_pos_reg && (bx_s >= S_L_FACE) && (bx_s - S_BALL_SPEED <= S_L_FACE) && overlap_l;
    assign hit_r = dx_pos_reg && (bx_s + S_BALL_SIZE <= S_R_FACE)
                   && (bx_s + S_BALL_SIZE + S_BALL_SPEED >= S_R_FACE) && overlap_r;
    // Leaving through the left wall scores for the right player and vice versa.
    assign miss_left_wall  = !dx_pos_reg && (bx_s - S_BALL_SPEED < 12'sd0);
    assign miss_right_wall = dx_pos_reg && (bx_s + S_BALL_SIZE + S_BALL_SPEED > S_H_RES);

    assign score_l_inc   = score_l_reg + 4'd1;
    assign score_r_inc   = score_r_reg + 4'd1;
    assign serve_cnt_inc = serve_cnt_reg + 8'd1;

    always_comb begin
        y_new  = ball_y_reg;
        dy_new = dy_pos_reg;
        if (dy_pos_reg) begin
            if (by_dn > S_BALL_Y_MAX) begin
                y_new  = BALL_Y_MAX;
                dy_new = 1'b0;
            end else begin
                y_new = by_dn[10:0];
            end
        end else begin
            if (by_up < 12'sd0) begin
                y_new  = 11'd0;
                dy_new = 1'b1;
            end else begin
                y_new = by_up[10:0];
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        ball_x_next      = ball_x_reg;
        ball_y_next      = ball_y_reg;
        dx_pos_next      = dx_pos_reg;
        dy_pos_next      = dy_pos_reg;
        pad_y_next       = pad_y_reg;
        score_l_next     = score_l_reg;
        score_r_next     = score_r_reg;
        serve_cnt_next   = serve_cnt_reg;
        point_pulse_next = 1'b0;

        case (state_reg)
            ST_IDLE, ST_OVER: begin
                // start takes priority over a coincident frame_tick
                if (start) begin
                    state_next     = ST_SERVE;
                    ball_x_next    = BALL_X0;
                    ball_y_next    = BALL_Y0;
                    pad_y_next     = {PAD_Y0, PAD_Y0};
                    score_l_next   = 4'd0;
                    score_r_next   = 4'd0;
                    serve_cnt_next = 8'd0;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    pad_y_next     = pad_moved;
                    serve_cnt_next = serve_cnt_inc;
                    if (serve_cnt_inc == SERVE_FRAMES) begin
                        state_next = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    pad_y_next  = pad_moved;
                    dy_pos_next = dy_new;
                    if (miss_left_wall || miss_right_wall) begin
                        ball_x_next      = BALL_X0;
                        ball_y_next      = BALL_Y0;
                        point_pulse_next = 1'b1;
                        serve_cnt_next   = 8'd0;
                        if (miss_left_wall) begin
                            score_r_next = score_r_inc;
                            dx_pos_next  = 1'b0;
                            state_next   = (score_r_inc == WIN_SCORE) ? ST_OVER : ST_SERVE;
                        end else begin
                            score_l_next = score_l_inc;
                            dx_pos_next  = 1'b1;
                            state_next   = (score_l_inc == WIN_SCORE) ? ST_OVER : ST_SERVE;
                        end
                    end else begin
                        ball_y_next = y_new;
                        if (hit_l) begin
                            ball_x_next = L_FACE;
                            dx_pos_next = 1'b1;
                        end else if (hit_r) begin
                            ball_x_next = R_BALL_X;
                            dx_pos_next = 1'b0;
                        end else if (dx_pos_reg) begin
                            ball_x_next = ball_x_reg + BALL_SPEED;
                        end else begin
                            ball_x_next = ball_x_reg - BALL_SPEED;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        game_over_next = (state_next == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ball_x_reg      <= BALL_X0;
            ball_y_reg      <= BALL_Y0;
            dx_pos_reg      <= 1'b1;
            dy_pos_reg      <= 1'b1;
            pad_y_reg       <= {PAD_Y0, PAD_Y0};
            score_l_reg     <= 4'd0;
            score_r_reg     <= 4'd0;
            serve_cnt_reg   <= 8'd0;
            point_pulse_reg <= 1'b0;
            game_over_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ball_x_reg      <= ball_x_next;
            ball_y_reg      <= ball_y_next;
            dx_pos_reg      <= dx_pos_next;
            dy_pos_reg      <= dy_pos_next;
            pad_y_reg       <= pad_y_next;
            score_l_reg     <= score_l_next;
            score_r_reg     <= score_r_next;
            serve_cnt_reg   <= serve_cnt_next;
            point_pulse_reg <= point_pulse_next;
            game_over_reg   <= game_over_next;
        end
    end

    assign ball_x      = ball_x_reg;
    assign ball_y      = ball_y_reg;
    assign padl_y      = pad_y_reg[0];
    assign padr_y      = pad_y_reg[1];
    assign score_l     = score_l_reg;
    assign score_r     = score_r_reg;
    assign point_pulse = point_pulse_reg;
    assign game_over   = game_over_reg;

endmodule
